// File: rtl/serial_bit_tx.sv
// serial_bit_tx: parallel-in, serial-out frame transmitter.
// Frame on sdo: start bit (0), DATA_W data bits LSB first, optional even
// parity bit, stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
// sdo and sdo_b are both registered; sdo_b is always the complement of sdo.
// Optional feature macro: SERIAL_BIT_TX_PARITY_EN (adds the PARITY state).
//
// Handshake: a word is accepted on a rising edge where tx_valid=1 and
// tx_ready=1. tx_ready is high only in IDLE. tx_valid may stay high while
// busy; the word is simply taken at the next IDLE edge. tx_data is sampled
// only on the accepting edge.
module serial_bit_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sdo,
    output logic              sdo_b,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SERIAL_BIT_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [DATA_W-1:0]   w_shift_dn;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [BIT_W-1:0]    r_bit;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic                r_sdo;
    logic                w_sdo_nxt;
    logic                r_sdo_b;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_baud_last;
`ifdef SERIAL_BIT_TX_PARITY_EN
    logic                r_parity;
    logic                w_parity_nxt;
`endif

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_shift_dn  = r_shift >> 1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; the serial level for the coming
    // bit is computed here so sdo itself comes straight from a flop.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit;
        w_sdo_nxt    = r_sdo;
        w_done_nxt   = 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_sdo_nxt  = 1'b1;
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (tx_valid) begin
                    w_shift_nxt  = tx_data;
`ifdef SERIAL_BIT_TX_PARITY_EN
                    w_parity_nxt = ^tx_data;
`endif
                    w_state_nxt  = ST_START;
                    w_sdo_nxt    = 1'b0;
                end
            end
            ST_START: begin
                w_baud_nxt = r_baud + 1'b1;
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = ST_DATA;
                    w_sdo_nxt   = r_shift[0];
                end
            end
            ST_DATA: begin
                w_baud_nxt = r_baud + 1'b1;
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_bit == BIT_LAST) begin
`ifdef SERIAL_BIT_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_sdo_nxt   = r_parity;
`else
                        w_state_nxt = ST_STOP;
                        w_sdo_nxt   = 1'b1;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = w_shift_dn;
                        w_sdo_nxt   = w_shift_dn[0];
                    end
                end
            end
`ifdef SERIAL_BIT_TX_PARITY_EN
            ST_PARITY: begin
                w_baud_nxt = r_baud + 1'b1;
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = ST_STOP;
                    w_sdo_nxt   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                w_baud_nxt = r_baud + 1'b1;
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                    w_sdo_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sdo_nxt   = 1'b1;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Datapath registers: shift register, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_sdo    <= 1'b1;
            r_sdo_b  <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_shift  <= w_shift_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_sdo    <= w_sdo_nxt;
            r_sdo_b  <= ~w_sdo_nxt;
            r_done   <= w_done_nxt;
`ifdef SERIAL_BIT_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign tx_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign sdo       = r_sdo;
    assign sdo_b     = r_sdo_b;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: reset checks, a table of directed frames,
// hand-written back-to-back and reset-mid-frame sequences, then random frames.
// Expected serial levels come from a slot-based frame model.
module tb_serial_bit_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_BIT_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int FL = (DW + 2 + PAR_EN) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          sdo;
    logic          sdo_b;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cyc_q[$];

    serial_bit_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sdo      (sdo),
        .sdo_b    (sdo_b),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          corrupt;  // flip tx_data mid-frame
        logic          exp_par;  // expected even parity bit
    } vec_t;

    vec_t vecs[8];

    task automatic check_bit(input string name, input logic act, input logic exp, input int k);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, k, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame model: cycle k (1..FL) after the accepting edge falls in slot
    // (k-1)/CPB: slot 0 start, 1..DW data LSB first, then parity, then stop.
    function automatic logic exp_bit(input logic [DW-1:0] d, input logic par, input int k);
        int slot;
        slot = (k - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DW) return d[slot-1];
        if (PAR_EN == 1 && slot == DW + 1) return par;
        return 1'b1;
    endfunction

    task automatic check_idle_outputs(input int k);
        check_bit("idle_sdo", sdo, 1'b1, k);
        check_bit("idle_sdo_b", sdo_b, 1'b0, k);
        check_bit("idle_busy", busy, 1'b0, k);
        check_bit("idle_done", done, 1'b0, k);
        check_bit("idle_ready", tx_ready, 1'b1, k);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle_outputs(i);
        end
    endtask

    // Present a word; it is accepted at the next rising edge.
    task automatic handshake(input logic [DW-1:0] d, input bit hold);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Follow one frame from the cycle after the accepting edge up to and
    // including the done cycle; ends at the done cycle's falling edge.
    task automatic watch_frame(input logic [DW-1:0] d, input logic par, input bit corrupt);
        logic e;
        for (int k = 1; k <= FL; k++) begin
            @(negedge clk);
            if (corrupt && k == 3 * CPB) tx_data = ~d;
            e = exp_bit(d, par, k);
            check_bit("sdo", sdo, e, k);
            check_bit("sdo_b", sdo_b, ~e, k);
            check_bit("busy", busy, 1'b1, k);
            check_bit("done_early", done, 1'b0, k);
            check_bit("ready_busy", tx_ready, 1'b0, k);
        end
        @(negedge clk);
        check_bit("done_pulse", done, 1'b1, FL + 1);
        check_bit("done_busy", busy, 1'b0, FL + 1);
        check_bit("done_sdo", sdo, 1'b1, FL + 1);
        check_bit("done_sdo_b", sdo_b, 1'b0, FL + 1);
        check_bit("done_ready", tx_ready, 1'b1, FL + 1);
        done_cyc_q.push_back(cyc);
    endtask

    initial begin
        logic [DW-1:0] d;
        int gap;

        vecs[0] = '{data: 8'hA5, corrupt: 1'b0, exp_par: 1'b0};
        vecs[1] = '{data: 8'hFF, corrupt: 1'b1, exp_par: 1'b0};
        vecs[2] = '{data: 8'h07, corrupt: 1'b0, exp_par: 1'b1};
        vecs[3] = '{data: 8'h03, corrupt: 1'b0, exp_par: 1'b0};
        vecs[4] = '{data: 8'h00, corrupt: 1'b0, exp_par: 1'b0};
        vecs[5] = '{data: 8'h80, corrupt: 1'b1, exp_par: 1'b1};
        vecs[6] = '{data: 8'h01, corrupt: 1'b0, exp_par: 1'b1};
        vecs[7] = '{data: 8'h5A, corrupt: 1'b0, exp_par: 1'b0};

        // Reset with tx_valid asserted: nothing may be accepted.
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        #1;
        check_idle_outputs(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs(3);
        tx_valid = 1'b0;
        rst      = 1'b0;
        idle_check(2);

        // Directed table.
        foreach (vecs[i]) begin
            handshake(vecs[i].data, 1'b0);
            watch_frame(vecs[i].data, vecs[i].exp_par, vecs[i].corrupt);
            idle_check(1 + (i % 2));
        end

        // Back-to-back with tx_valid held high throughout.
        handshake(8'h3C, 1'b1);
        tx_data = 8'hC3;
        watch_frame(8'h3C, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        watch_frame(8'hC3, 1'b0, 1'b0);
        check_int("b2b_done_spacing",
                  done_cyc_q[done_cyc_q.size()-1] - done_cyc_q[done_cyc_q.size()-2], FL + 1);
        idle_check(1);

        // Reset in the middle of data bit 3 (cycles 4*CPB+1..5*CPB).
        handshake(8'h55, 1'b0);
        for (int k = 1; k <= 4 * CPB + 2; k++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_bit("rst_mid_sdo", sdo, 1'b1, 0);
        check_bit("rst_mid_sdo_b", sdo_b, 1'b0, 0);
        check_bit("rst_mid_busy", busy, 1'b0, 0);
        check_bit("rst_mid_done", done, 1'b0, 0);
        check_bit("rst_mid_ready", tx_ready, 1'b1, 0);
        idle_check(3);
        rst = 1'b0;
        idle_check(2);
        handshake(8'h01, 1'b0);
        watch_frame(8'h01, 1'b1, 1'b0);
        idle_check(1);

        // Random frames, sometimes back-to-back.
        for (int n = 0; n < 16; n++) begin
            d   = DW'($urandom_range(0, 255));
            gap = $urandom_range(0, 3);
            if (gap > 0) idle_check(gap);
            handshake(d, 1'b0);
            watch_frame(d, 1'($countones(d) % 2), 1'b0);
        end
        idle_check(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
